regfile_mp_sb: RTL

Parametrised general-purpose register file for the pipelined RISC-V datapath.
- Configurable depth, width and number of read ports.
- x0 is hard-wired to zero.
- Reads are synchronous, with write-to-read bypass.
- An integrated pending-write scoreboard lets decode detect RAW hazards without a separate hazard table.

---
 rtl/rv_regfile_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 50 +++++
 rtl/regfile_mp_sb.sv | 80 ++++++++
 3 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared constants and helpers for the register file, decode and hazard units.
// Defaults here are the baseline RV32 integer register file geometry.
package rv_regfile_pkg;

  localparam int ZERO_IDX      = 0;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_NUM_REGS  = 32;

  // Low bit of port p's field inside a packed multi-port vector.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: write bypass, x0 override, rd_en hold and
// the registered pending flag for the addressed register.
module regfile_read_port
  import rv_regfile_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 wr_commit,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [WORD_SIZE-1:0] stored_data,
  input  logic                 pend_next,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_pending
);

  logic                 is_zero_p0;
  logic [WORD_SIZE-1:0] byp_data_p0;
  logic                 byp_pend_p0;

  // Stage p0: select bypassed data and post-edge pending state
  always_comb begin
    is_zero_p0  = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_IDX));
    byp_data_p0 = stored_data;
    if (wr_commit && (wr_addr == rd_addr)) byp_data_p0 = wr_data;
    byp_pend_p0 = pend_next;
    if (is_zero_p0) begin
      byp_data_p0 = '0;
      byp_pend_p0 = 1'b0;
    end
  end

  // Stage p1: registered read result, held while rd_en is low
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data    <= '0;
      rd_pending <= 1'b0;
    end else if (rd_en) begin
      rd_data    <= byp_data_p0;
      rd_pending <= byp_pend_p0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file with write-to-read bypass and an integrated
// pending-write scoreboard used by decode for RAW hazard detection.
module regfile_mp_sb
  import rv_regfile_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int ADDR_W       = $clog2(NUM_REGS),
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [WORD_SIZE-1:0]              wr_data,
  input  logic                              rsv_en,
  input  logic [ADDR_W-1:0]                 rsv_addr,
  input  logic [NUM_RD_PORTS-1:0]           rd_en,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD_PORTS*WORD_SIZE-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]           rd_pending,
  output logic [NUM_REGS-1:0]               pending_mask
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  pending_q;
  logic [NUM_REGS-1:0]  pending_next;
  logic                 wr_commit;
  logic                 rsv_commit;

  // Stage p0: drop x0 traffic; reservation is applied after the clear so it wins
  always_comb begin
    wr_commit  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_IDX)));
    rsv_commit = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX)));
    pending_next = pending_q;
    if (wr_commit)  pending_next[wr_addr]  = 1'b0;
    if (rsv_commit) pending_next[rsv_addr] = 1'b1;
  end

  // Stage p1: storage and scoreboard state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wr_commit) regs[wr_addr] <= wr_data;
      pending_q <= pending_next;
    end
  end

  assign pending_mask = pending_q;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    localparam int ALO = slice_lo(p, ADDR_W);
    localparam int DLO = slice_lo(p, WORD_SIZE);

    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[ALO +: ADDR_W];

    regfile_read_port #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_W    (ADDR_W),
      .ZERO_REG  (ZERO_REG)
    ) u_port (
      .clock       (clock),
      .reset_n     (reset_n),
      .rd_en       (rd_en[p]),
      .rd_addr     (port_addr),
      .wr_commit   (wr_commit),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .stored_data (regs[port_addr]),
      .pend_next   (pending_next[port_addr]),
      .rd_data     (rd_data[DLO +: WORD_SIZE]),
      .rd_pending  (rd_pending[p])
    );
  end

endmodule
